// File: rtl/alu_seq_addsub.sv
// Multi-cycle Y86 execute unit: add/sub/and/xor on WIDTH-bit operands,
// one SLICE-bit chunk per clock with a registered carry between chunks.
// Valid/ready on both sides; holds the Y86 condition codes ZF/SF/OF.
module alu_seq_addsub #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              alu_fun,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    set_cc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    zf,
  output logic                    sf,
  output logic                    of
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] FUN_ADD = 2'd0;
  localparam logic [1:0] FUN_SUB = 2'd1;
  localparam logic [1:0] FUN_AND = 2'd2;
  localparam logic [1:0] FUN_XOR = 2'd3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;      // holds ~b for sub
  logic [1:0]              fun_q;
  logic                    setcc_q;
  logic                    carry;
  logic [IDX_W-1:0]        idx;

  logic [SLICE-1:0]        a_s;
  logic [SLICE-1:0]        b_s;
  logic [SLICE:0]          sum_s;
  logic [SLICE-1:0]        r_s;
  logic                    c_s;
  logic                    last;

  // Signed overflow from operand/result sign bits. For sub, b_q already
  // holds ~b, so "a sign == stored b sign" is the same as "a sign != b sign".
  function automatic logic signed_ovf(input logic [1:0] fun, input logic a_msb,
                                      input logic bq_msb, input logic r_msb);
    return ((fun == FUN_ADD) || (fun == FUN_SUB)) &&
           (a_msb == bq_msb) && (r_msb != a_msb);
  endfunction

  assign in_ready = (state == IDLE) && !rst;

  // Select the current slice and compute its result and carry-out.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IDX_W'(i)) begin
        a_s = a_q[i*SLICE +: SLICE];
        b_s = b_q[i*SLICE +: SLICE];
      end
    end
    sum_s = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry};
    r_s   = sum_s[SLICE-1:0];
    c_s   = sum_s[SLICE];
    case (fun_q)
      FUN_AND: begin r_s = a_s & b_s; c_s = 1'b0; end
      FUN_XOR: begin r_s = a_s ^ b_s; c_s = 1'b0; end
      default: ;
    endcase
    last = (idx == IDX_W'(NSLICE - 1));
  end

  // Control FSM, slice write-back and condition-code register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      result    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      zf        <= 1'b1;
      sf        <= 1'b0;
      of        <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      fun_q     <= FUN_ADD;
      setcc_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= (alu_fun == FUN_SUB) ? ~b : b;
            fun_q   <= alu_fun;
            setcc_q <= set_cc;
            carry   <= (alu_fun == FUN_SUB);
            idx     <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) result[i*SLICE +: SLICE] <= r_s;
          end
          carry <= c_s;
          if (last) begin
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            overflow  <= signed_ovf(fun_q, a_q[WIDTH-1], b_q[WIDTH-1], r_s[SLICE-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            if (setcc_q) begin
              zf <= (result == '0);
              sf <= result[WIDTH-1];
              of <= overflow;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_addsub.sv
// Directed bench for alu_seq_addsub: hand-computed vectors for each ALU
// function, flag updates, backpressure and reset during an operation.
module tb_alu_seq_addsub;

  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int NSLICE = WIDTH / SLICE;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_fun;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              set_cc;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              overflow;
  logic              zf;
  logic              sf;
  logic              of;

  int   vectors     = 0;
  int   miscompares = 0;
  logic ezf, esf, eof;

  always #5 clk = ~clk;

  alu_seq_addsub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_fun   (alu_fun),
    .a         (a),
    .b         (b),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "/zf"}, {63'd0, zf}, {63'd0, ezf});
    chk({tag, "/sf"}, {63'd0, sf}, {63'd0, esf});
    chk({tag, "/of"}, {63'd0, of}, {63'd0, eof});
  endtask

  // Issue one operation, scramble inputs after accept, check latency,
  // optional backpressure, the output handshake and the resulting flags.
  task automatic run_op(input string tag, input logic [1:0] fun,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic sc, input logic [63:0] er, input logic eo,
                        input int hold, input logic early);
    @(negedge clk);
    out_ready = early;
    in_valid  = 1'b1;
    alu_fun   = fun;
    a         = av;
    b         = bv;
    set_cc    = sc;
    chk({tag, "/in_ready_idle"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    alu_fun  = ~fun;
    set_cc   = ~sc;
    for (int k = 0; k < NSLICE; k++) begin
      chk({tag, "/out_valid_calc"}, {63'd0, out_valid}, 64'd0);
      chk({tag, "/in_ready_calc"}, {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    chk({tag, "/out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "/result"}, result, er);
    chk({tag, "/overflow"}, {63'd0, overflow}, {63'd0, eo});
    for (int h = 0; h < hold; h++) begin
      in_valid = ((h % 2) == 0);
      @(negedge clk);
      chk({tag, "/hold_out_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "/hold_result"}, result, er);
      chk({tag, "/hold_overflow"}, {63'd0, overflow}, {63'd0, eo});
      chk({tag, "/hold_in_ready"}, {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "/out_valid_after"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "/in_ready_after"}, {63'd0, in_ready}, 64'd1);
    if (sc) begin
      ezf = (er == 64'd0);
      esf = er[63];
      eof = eo;
    end
    chk_flags(tag);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_fun   = 2'd0;
    a         = '0;
    b         = '0;
    set_cc    = 1'b0;
    out_ready = 1'b0;
    ezf = 1'b1; esf = 1'b0; eof = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset/result", result, 64'd0);
    chk("reset/overflow", {63'd0, overflow}, 64'd0);
    chk("reset/out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset/in_ready_in_rst", {63'd0, in_ready}, 64'd0);
    chk_flags("reset");
    rst = 1'b0;
    #1;
    chk("reset/in_ready", {63'd0, in_ready}, 64'd1);

    run_op("sub_ovf", 2'd1, 64'h0000_0000_0000_C350, 64'h8000_0000_0000_8350, 1'b1,
           64'h8000_0000_0000_4000, 1'b1, 0, 1'b0);
    run_op("add_carry", 2'd0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b1,
           64'h0000_0000_0001_0000, 1'b0, 0, 1'b0);
    run_op("add_wrap", 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
           64'd0, 1'b0, 0, 1'b0);
    run_op("add_ovf_nocc", 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
           64'h8000_0000_0000_0000, 1'b1, 0, 1'b0);
    run_op("and_bp", 2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1,
           64'hF000_F000_F000_F000, 1'b0, 3, 1'b0);
    run_op("xor_eq", 2'd3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
           64'd0, 1'b0, 0, 1'b1);
    run_op("sub_neg", 2'd1, 64'd5, 64'd7, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, 1'b0);
    run_op("sub_min_ovf", 2'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b0);

    // Reset while the slice index is 2.
    @(negedge clk);
    in_valid = 1'b1; alu_fun = 2'd1; a = 64'd100; b = 64'd3; set_cc = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ezf = 1'b1; esf = 1'b0; eof = 1'b0;
    chk("rst_mid/result", result, 64'd0);
    chk("rst_mid/overflow", {63'd0, overflow}, 64'd0);
    chk("rst_mid/out_valid", {63'd0, out_valid}, 64'd0);
    chk_flags("rst_mid");
    rst = 1'b0;
    #1;
    chk("rst_mid/in_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_mid/no_stale_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_mid/zf_held", {63'd0, zf}, 64'd1);
    end
    out_ready = 1'b0;

    run_op("add_after_rst", 2'd0, 64'd2, 64'd3, 1'b1, 64'd5, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
